// File: rtl/grid_pkg.sv
// ---------------------------------------------------------------------------
// grid_pkg
// Shared definitions for the grid loader and the downstream roll-removal
// stage: default grid geometry, the ASCII codes that make up the puzzle
// text, and the loader state encoding.
// ---------------------------------------------------------------------------
package grid_pkg;

   // Default geometry, shared with the downstream exhaustive_access stage.
   localparam int GRID_WIDTH_DEF = 10;
   localparam int GRID_DEPTH_DEF = 10;

   // Input alphabet.
   localparam logic [7:0] CH_ROLL  = 8'h40;
   localparam logic [7:0] CH_EMPTY = 8'h2E;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_CR    = 8'h0D;

   // Loader state encoding, kept as plain constants for older consumers.
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_LOAD = 2'd1;
   localparam state_t ST_DONE = 2'd2;
   localparam state_t ST_ERR  = 2'd3;

endpackage

// File: rtl/char_classify.sv
// ---------------------------------------------------------------------------
// char_classify
// Purely combinational decode of one input byte into the classes the loader
// FSM cares about. Exactly one output is high for any byte.
//
// Ports:
//   ch        in  8  ASCII byte
//   is_roll   out 1  byte is '@'
//   is_empty  out 1  byte is '.'
//   is_lf     out 1  byte is '\n'
//   is_cr     out 1  byte is '\r'
//   is_bad    out 1  byte is anything else
// ---------------------------------------------------------------------------
module char_classify
   import grid_pkg::*;
(
   input  logic [7:0] ch,
   output logic       is_roll,
   output logic       is_empty,
   output logic       is_lf,
   output logic       is_cr,
   output logic       is_bad
);

   assign is_roll  = (ch == CH_ROLL);
   assign is_empty = (ch == CH_EMPTY);
   assign is_lf    = (ch == CH_LF);
   assign is_cr    = (ch == CH_CR);

   // Anything outside the four legal characters is a format error.
   assign is_bad   = ~(is_roll | is_empty | is_lf | is_cr);

endmodule

// File: rtl/grid_char_loader.sv
// ---------------------------------------------------------------------------
// grid_char_loader
// Accepts the puzzle text one byte per valid/ready handshake and builds the
// DEPTH x WIDTH occupancy bitmap plus a count of rolls. A well-formed file
// ends in DONE with grid_valid high; any malformed input parks the loader in
// ERR with a sticky err flag until the next start or rst.
//
// Ports:
//   clk         in  1            clock
//   rst         in  1            synchronous active-high reset
//   start       in  1            pulse: clear and begin a new load
//   ch_valid    in  1            byte present on ch_data
//   ch_data     in  8            ASCII byte
//   ch_last     in  1            ch_data is the final byte of the file
//   ch_ready    out 1            byte accepted this cycle when ch_valid
//   grid_out    out WIDTH*DEPTH  bit r*WIDTH+c set iff cell (r,c) is '@'
//                                (consumers unpack to grid_in[r][c])
//   grid_valid  out 1            grid_out / roll_count final and stable
//   roll_count  out CNT_W        number of '@' accepted
//   err         out 1            sticky format error
// ---------------------------------------------------------------------------
module grid_char_loader
   import grid_pkg::*;
#(
   parameter int WIDTH = GRID_WIDTH_DEF,
   parameter int DEPTH = GRID_DEPTH_DEF,
   parameter int CNT_W = $clog2(WIDTH*DEPTH+1)
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   ch_valid,
   input  logic [7:0]             ch_data,
   input  logic                   ch_last,
   output logic                   ch_ready,
   output logic [WIDTH*DEPTH-1:0] grid_out,
   output logic                   grid_valid,
   output logic [CNT_W-1:0]       roll_count,
   output logic                   err
);

   localparam int GRID_W = WIDTH * DEPTH;
   localparam int ROW_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int COL_W  = $clog2(WIDTH + 1);

   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DEPTH - 1);
   localparam logic [COL_W-1:0] COL_FULL = COL_W'(WIDTH);

   state_t             state;
   logic [ROW_W-1:0]   row;
   logic [COL_W-1:0]   col;

   state_t             state_n;
   logic [ROW_W-1:0]   row_n;
   logic [COL_W-1:0]   col_n;
   logic               set_bit;
   logic               accept;

   logic               is_roll;
   logic               is_empty;
   logic               is_lf;
   logic               is_cr;
   logic               is_bad;

   char_classify u_classify (
      .ch       (ch_data),
      .is_roll  (is_roll),
      .is_empty (is_empty),
      .is_lf    (is_lf),
      .is_cr    (is_cr),
      .is_bad   (is_bad)
   );

   // A start pulse wins over any byte in the same cycle, so ready is dropped
   // while start is high to keep the handshake honest.
   assign ch_ready   = (state == ST_LOAD) & ~start;
   assign accept     = ch_valid & ch_ready;
   assign grid_valid = (state == ST_DONE);
   assign err        = (state == ST_ERR);

   // Next-state decode for one accepted byte. The character action is applied
   // first; ch_last then decides between DONE and an early-end error, except
   // that an error raised by the byte itself always stands.
   always_comb begin
      state_n = state;
      row_n   = row;
      col_n   = col;
      set_bit = 1'b0;
      if (accept) begin
         if (is_roll | is_empty) begin
            if (col == COL_FULL) begin
               state_n = ST_ERR;
            end else begin
               col_n   = col + 1'b1;
               set_bit = is_roll;
            end
         end else if (is_lf) begin
            if (col != COL_FULL) begin
               state_n = ST_ERR;
            end else if (row == ROW_LAST) begin
               state_n = ST_DONE;
            end else begin
               row_n = row + 1'b1;
               col_n = '0;
            end
         end else if (is_bad) begin
            state_n = ST_ERR;
         end
         if (ch_last && (state_n != ST_ERR)) begin
            if ((row_n == ROW_LAST) && (col_n == COL_FULL)) begin
               state_n = ST_DONE;
            end else begin
               state_n = ST_ERR;
            end
         end
      end
   end

   // State, position counters and the bitmap. Both rst and start wipe any
   // previous grid so no residue from an aborted load can leak into the next.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         row        <= '0;
         col        <= '0;
         grid_out   <= '0;
         roll_count <= '0;
      end else if (start) begin
         state      <= ST_LOAD;
         row        <= '0;
         col        <= '0;
         grid_out   <= '0;
         roll_count <= '0;
      end else if (state == ST_LOAD) begin
         state <= state_n;
         row   <= row_n;
         col   <= col_n;
         if (set_bit) begin
            grid_out   <= grid_out | (GRID_W'(1) << (int'(row) * WIDTH + int'(col)));
            roll_count <= roll_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_grid_char_loader.sv
// ---------------------------------------------------------------------------
// tb_grid_char_loader
// Self-checking bench for grid_char_loader using the 10x10 sample grid.
// Expected grids are derived from the sample text and queued when a stream
// is sent; they are popped and compared when the loader reports a result.
// ---------------------------------------------------------------------------
module tb_grid_char_loader;

   localparam int WIDTH  = 10;
   localparam int DEPTH  = 10;
   localparam int GRID_W = WIDTH * DEPTH;
   localparam int CNT_W  = $clog2(GRID_W + 1);

   typedef struct {
      logic [GRID_W-1:0] grid;
      logic [CNT_W-1:0]  count;
      bit                isErr;
   } exp_t;

   logic              clk;
   logic              rst;
   logic              start;
   logic              ch_valid;
   logic [7:0]        ch_data;
   logic              ch_last;
   logic              ch_ready;
   logic [GRID_W-1:0] grid_out;
   logic              grid_valid;
   logic [CNT_W-1:0]  roll_count;
   logic              err;

   int checks   = 0;
   int failures = 0;

   exp_t       sb[$];
   logic [8:0] byteQ[$];

   string rows[DEPTH] = '{
      "..@@.@@@@.",
      "@@@.@.@.@@",
      "@@@@@.@.@@",
      "@.@@@@..@.",
      "@@.@@@@.@@",
      ".@@@@@@@.@",
      ".@.@.@.@@@",
      "@.@@@.@@@@",
      ".@@@@@@@@.",
      "@.@.@@@.@."
   };

   grid_char_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .ch_valid   (ch_valid),
      .ch_data    (ch_data),
      .ch_last    (ch_last),
      .ch_ready   (ch_ready),
      .grid_out   (grid_out),
      .grid_valid (grid_valid),
      .roll_count (roll_count),
      .err        (err)
   );

   // 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Reference result for the clean sample, derived from the text.
   function automatic exp_t expectClean();
      exp_t e;
      e.grid  = '0;
      e.count = '0;
      e.isErr = 1'b0;
      for (int r = 0; r < DEPTH; r++) begin
         for (int c = 0; c < WIDTH; c++) begin
            if (rows[r][c] == 8'h40) begin
               e.grid[r*WIDTH+c] = 1'b1;
               e.count           = e.count + 1'b1;
            end
         end
      end
      return e;
   endfunction

   function automatic exp_t expectErr();
      exp_t e;
      e.grid  = '0;
      e.count = '0;
      e.isErr = 1'b1;
      return e;
   endfunction

   // Build the byte stream; bit 8 of each entry is ch_last.
   function automatic void buildStream(input bit crlf, input bit finalNl);
      logic [8:0] tmp;
      byteQ.delete();
      for (int r = 0; r < DEPTH; r++) begin
         for (int c = 0; c < WIDTH; c++) byteQ.push_back({1'b0, rows[r][c]});
         if (r < DEPTH-1 || finalNl) begin
            if (crlf) byteQ.push_back(9'h00D);
            byteQ.push_back(9'h00A);
         end
      end
      tmp    = byteQ.pop_back();
      tmp[8] = 1'b1;
      byteQ.push_back(tmp);
   endfunction

   // Pulse start; optionally present a byte alongside it, which must be refused.
   task automatic doStart(input bit withByte);
      @(negedge clk);
      start = 1'b1;
      if (withByte) begin
         ch_valid = 1'b1;
         ch_data  = 8'h40;
         ch_last  = 1'b0;
         #1;
         checkOutput("ready_during_start", ch_ready, 1'b0);
      end
      @(negedge clk);
      start    = 1'b0;
      ch_valid = 1'b0;
   endtask

   // Drive byteQ (up to maxBytes) with optional random idle cycles. Stops
   // early once the loader reports DONE or ERR. Returns at the negedge after
   // the final accepted byte, so a completed load is already visible.
   task automatic applyStimulus(input bit gaps, input int maxBytes, output int accepted);
      int  idx    = 0;
      int  budget = 0;
      bit  stopped = 1'b0;
      accepted = 0;
      while (!stopped && idx < byteQ.size() && idx < maxBytes && budget < 5000) begin
         @(negedge clk);
         budget++;
         if (err || grid_valid) begin
            stopped = 1'b1;
         end else if (gaps && $urandom_range(0, 1) == 0) begin
            ch_valid = 1'b0;
            ch_last  = 1'b0;
         end else begin
            ch_valid = 1'b1;
            ch_data  = byteQ[idx][7:0];
            ch_last  = byteQ[idx][8];
            if (ch_ready) begin
               accepted++;
               idx++;
            end
         end
      end
      if (budget >= 5000) checkOutput("stim_budget", 1'b1, 1'b0);
      if (!stopped) @(negedge clk);
      ch_valid = 1'b0;
      ch_last  = 1'b0;
   endtask

   // Wait (bounded) for the loader to report, then compare against the queue.
   task automatic waitResult(input string tag);
      exp_t e;
      int   n = 0;
      while (!(grid_valid || err) && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, "_reported"}, grid_valid | err, 1'b1);
      if (sb.size() == 0) begin
         checkOutput({tag, "_sb_empty"}, 1'b1, 1'b0);
      end else begin
         e = sb.pop_front();
         checkOutput({tag, "_err"}, err, e.isErr);
         checkOutput({tag, "_valid"}, grid_valid, !e.isErr);
         checkOutput({tag, "_ready"}, ch_ready, 1'b0);
         if (!e.isErr) begin
            checkOutput({tag, "_grid"}, grid_out, e.grid);
            checkOutput({tag, "_count"}, roll_count, e.count);
         end
      end
   endtask

   initial begin
      int acc;
      rst      = 1'b1;
      start    = 1'b0;
      ch_valid = 1'b0;
      ch_data  = 8'h00;
      ch_last  = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset state.
      checkOutput("rst_ready", ch_ready, 1'b0);
      checkOutput("rst_valid", grid_valid, 1'b0);
      checkOutput("rst_err", err, 1'b0);
      checkOutput("rst_grid", grid_out, '0);
      checkOutput("rst_count", roll_count, '0);

      // Clean LF stream, ch_last on the final newline.
      $display("[TB] LF stream");
      doStart(1'b1);
      checkOutput("start_byte_ignored", roll_count, '0);
      buildStream(1'b0, 1'b1);
      sb.push_back(expectClean());
      applyStimulus(1'b0, 1000, acc);
      checkOutput("lf_latency_valid", grid_valid, 1'b1);
      checkOutput("lf_row0_bits", grid_out[9:0], 10'b0111101100);
      checkOutput("lf_bit99", grid_out[99], 1'b0);
      checkOutput("lf_count71", roll_count, 71);
      waitResult("lf");

      // Bytes offered after DONE must be back-pressured and leave outputs alone.
      @(negedge clk);
      ch_valid = 1'b1;
      ch_data  = 8'h40;
      #1;
      checkOutput("done_backpressure", ch_ready, 1'b0);
      @(negedge clk);
      ch_valid = 1'b0;
      checkOutput("done_hold_count", roll_count, 71);
      checkOutput("done_hold_valid", grid_valid, 1'b1);

      // CRLF endings, no final newline, ch_last on the last '.'.
      $display("[TB] CRLF stream");
      doStart(1'b0);
      buildStream(1'b1, 1'b0);
      sb.push_back(expectClean());
      applyStimulus(1'b0, 1000, acc);
      checkOutput("crlf_latency_valid", grid_valid, 1'b1);
      waitResult("crlf");

      // Random ch_valid gaps; exactly 110 bytes accepted before DONE.
      $display("[TB] gapped stream");
      doStart(1'b0);
      buildStream(1'b0, 1'b1);
      sb.push_back(expectClean());
      applyStimulus(1'b1, 1000, acc);
      checkOutput("gap_accepted", acc, 110);
      checkOutput("gap_latency_valid", grid_valid, 1'b1);
      waitResult("gap");

      // Row 3 one character short.
      $display("[TB] short row");
      doStart(1'b0);
      buildStream(1'b0, 1'b1);
      byteQ.delete(3*(WIDTH+1));
      sb.push_back(expectErr());
      applyStimulus(1'b0, 1000, acc);
      checkOutput("short_accepted", acc, 43);
      waitResult("short");
      @(negedge clk);
      checkOutput("short_err_sticky", err, 1'b1);

      // Recovery with a clean stream.
      doStart(1'b0);
      buildStream(1'b0, 1'b1);
      sb.push_back(expectClean());
      applyStimulus(1'b0, 1000, acc);
      waitResult("recover");

      // Illegal byte in the middle of row 5.
      $display("[TB] illegal byte");
      doStart(1'b0);
      buildStream(1'b0, 1'b1);
      byteQ[5*(WIDTH+1)+4] = 9'h078;
      sb.push_back(expectErr());
      applyStimulus(1'b0, 1000, acc);
      checkOutput("badch_accepted", acc, 60);
      waitResult("badch");

      // File ends early: ch_last on the newline after row 5.
      $display("[TB] early end");
      doStart(1'b0);
      buildStream(1'b0, 1'b1);
      while (byteQ.size() > 6*(WIDTH+1)) void'(byteQ.pop_back());
      byteQ[6*(WIDTH+1)-1] = 9'h10A;
      sb.push_back(expectErr());
      applyStimulus(1'b0, 1000, acc);
      checkOutput("early_accepted", acc, 66);
      waitResult("early");

      // Reset in the middle of a load, then a fresh clean load.
      $display("[TB] reset mid-load");
      doStart(1'b0);
      buildStream(1'b0, 1'b1);
      applyStimulus(1'b0, 40, acc);
      checkOutput("midrst_accepted", acc, 40);
      checkOutput("midrst_partial_nonzero", (roll_count != 0), 1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("midrst_ready", ch_ready, 1'b0);
      checkOutput("midrst_valid", grid_valid, 1'b0);
      checkOutput("midrst_err", err, 1'b0);
      checkOutput("midrst_grid", grid_out, '0);
      checkOutput("midrst_count", roll_count, '0);
      doStart(1'b0);
      buildStream(1'b0, 1'b1);
      sb.push_back(expectClean());
      applyStimulus(1'b0, 1000, acc);
      waitResult("after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/grid_char_loader.md
Name: grid_char_loader

Overview:
Upstream loader for the exhaustive_access roll-removal stage. It takes the puzzle input as a byte stream of '@', '.', '\n' and optional '\r', one byte per handshake. It builds the DEPTH x WIDTH occupancy bitmap, counts the rolls, and presents a stable grid with grid_valid. Malformed input (wrong row length, illegal character, early end) raises a sticky err and never produces grid_valid.

Parameters:
WIDTH, 10, columns per row (characters before each '\n')
DEPTH, 10, number of rows
CNT_W, $clog2(WIDTH*DEPTH+1), width of roll_count

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse: clear grid/counters and begin a new load (accepted in any state)
ch_valid  input  1  byte present on ch_data
ch_data  input  8  ASCII input byte
ch_last  input  1  qualifies ch_data as final byte of the file
ch_ready  output  1  loader accepts a byte this cycle
grid_out  output  WIDTH*DEPTH  bit r*WIDTH+c = 1 iff cell (r,c) is '@'; top level unpacks to grid_in[r][c]
grid_valid  output  1  grid_out and roll_count final and stable
roll_count  output  CNT_W  number of '@' accepted
err  output  1  sticky format error

Behaviour:
- Reset: state IDLE; ch_ready=0, grid_valid=0, err=0, grid_out=0, roll_count=0, row=col=0.
- States: IDLE, LOAD, DONE, ERR. ch_ready=1 only in LOAD; grid_valid=1 only in DONE; err=1 only in ERR.
- start, any state: next cycle grid_out=0, roll_count=0, row=col=0, state LOAD. A byte presented in the same cycle as start is not accepted.
- Accept = ch_valid & ch_ready. Actions in LOAD on accept:
  - '@' with col<WIDTH: set bit row*WIDTH+col, col+1, roll_count+1.
  - '.' with col<WIDTH: col+1.
  - '@' or '.' with col==WIDTH: row too long, go to ERR.
  - '\r' (0x0D): ignored; no counter change.
  - '\n' (0x0A) with col==WIDTH: if row==DEPTH-1, go to DONE; else row+1, col=0.
  - '\n' with col!=WIDTH: short row, go to ERR.
  - Any other byte: go to ERR.
- ch_last on an accepted byte: after applying that byte's action, the state is DONE if row==DEPTH-1 and col==WIDTH. A trailing newline is optional. Otherwise (early end) go to ERR. If the byte itself errors, ERR wins.
- Latency: grid_valid rises the cycle after the completing byte is accepted. grid_out is final at that edge. A full load takes exactly N accepted bytes plus 1 cycle.
- DONE: ch_ready=0 and outputs held until start or rst. Extra bytes after DONE are back-pressured, not consumed.
- ERR: ch_ready=0. grid_out and roll_count keep their partial values; consumers ignore them without grid_valid.
- Counters: row is $clog2(DEPTH) bits; col is $clog2(WIDTH+1) bits so it can hold WIDTH. No wrap-around; every overflow path goes to ERR.
- rst mid-load: returns to IDLE immediately with all outputs cleared; no partial grid is retained.

Decomposition:
- Shared package grid_pkg: character constants CH_ROLL=8'h40, CH_EMPTY=8'h2E, CH_LF=8'h0A, CH_CR=8'h0D; state enum {IDLE, LOAD, DONE, ERR}. exhaustive_access uses the same WIDTH/DEPTH defaults.
- Optional sub-module char_classify: combinational byte to {is_roll, is_empty, is_lf, is_cr, is_bad}. The FSM and bitmap register stay in grid_char_loader.

Test Plan:
- Stream the 10x10 sample (row 0 "..@@.@@@@.", row 9 "@.@.@@@.@.") with '\n' after every row and ch_last on the final '\n'. Required: grid_valid=1 one cycle later, roll_count=71, grid_out bits 2,3,5,6,7,8 set in row 0, bit 99 clear, err=0.
- Same sample with CRLF line endings, no final newline, ch_last on the last '.'. Required: identical grid_out, roll_count=71.
- Random ch_valid gaps (about 50% duty). Required: identical result to the first test; DONE only after exactly 110 accepted bytes.
- Row 3 sent with 9 characters then '\n'. Required: err=1 on the next cycle, ch_ready=0, grid_valid stays 0. A subsequent start followed by a clean stream gives roll_count=71.
- Byte 'x' mid-row, or ch_last after row 5. Required: err=1, grid_valid=0.
- rst asserted after 40 bytes, then start and a full clean stream. Required: all outputs 0 after rst; final roll_count=71 with no residue from the aborted load.
